// File: rtl/siso_frame_deser.sv
// Serial frame receiver: start 1, WIDTH data bits MSB first, stop 0.
// Optional even-parity slot before the stop bit via `define PARITY_CHECK_EN.
module siso_frame_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             perr_q;
  logic             par_bad_q;

`ifdef PARITY_CHECK_EN
  localparam state_t AFTER_DATA = S_PARITY;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      // Drain first; a good stop edge below may reload in the same cycle.
      if (valid_q && data_ready)
        valid_q <= 1'b0;
      if (bit_en) begin
        unique case (state_q)
          S_IDLE: begin
            par_bad_q <= 1'b0;
            if (serial_in) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
            end
          end
          S_DATA: begin
            shift_q <= {shift_q[WIDTH-2:0], serial_in};
            if (cnt_q == LAST) begin
              state_q <= AFTER_DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PARITY: begin
            par_bad_q <= (^shift_q) ^ serial_in;
            state_q   <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (serial_in) begin
              ferr_q <= 1'b1;
            end else if (par_bad_q) begin
              perr_q <= 1'b1;
            end else if (!valid_q || data_ready) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0 & perr_q;
`endif

endmodule
